// File: rtl/mux_4to1_8b.sv
// Registered 4-to-1 word multiplexer: {input_select2, input_select1} picks a/b/c/d,
// and the chosen word is presented on output_result one clock edge later.
module mux_4to1_8b #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] input_c,
    input  logic [WIDTH-1:0] input_d,
    input  logic             input_select1,
    input  logic             input_select2,
    output logic [WIDTH-1:0] output_result,
    input  logic             clk,
    input  logic             rst
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;

    assign sel = {input_select2, input_select1};

    always_comb begin
        result_d = input_a;
        case (sel)
            2'b00:   result_d = input_a;
            2'b01:   result_d = input_b;
            2'b10:   result_d = input_c;
            2'b11:   result_d = input_d;
            default: result_d = input_a;
        endcase
    end

    // Single register stage; reset wins over whatever word is being selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign output_result = result_q;

endmodule

// File: tb/tb_mux_4to1_8b.sv
// Self-checking bench for mux_4to1_8b: directed scenarios plus a randomized run,
// all checked against an array-indexed reference model with one-cycle delay.
module tb_mux_4to1_8b;

    logic [7:0] a, b, c, d;
    logic       s1, s2;
    logic       clk, rst;
    logic [7:0] res;

    int checks = 0;
    int errors = 0;

    mux_4to1_8b #(.WIDTH(8)) dut (
        .input_a       (a),
        .input_b       (b),
        .input_c       (c),
        .input_d       (d),
        .input_select1 (s1),
        .input_select2 (s2),
        .output_result (res),
        .clk           (clk),
        .rst           (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the word that should be registered given the inputs present now.
    function automatic logic [7:0] model(input logic r, input logic [7:0] wa, input logic [7:0] wb,
                                         input logic [7:0] wc, input logic [7:0] wd,
                                         input logic sl, input logic sh);
        logic [7:0] src [4];
        src[0] = wa; src[1] = wb; src[2] = wc; src[3] = wd;
        if (r) return 8'h00;
        return src[2 * int'(sh) + int'(sl)];
    endfunction

    // Capture expectation from the inputs, clock one edge, settle 1 time unit past it.
    task automatic step(output logic [7:0] exp);
        exp = model(rst, a, b, c, d, s1, s2);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1; a = 8'hFF; b = 8'h11; c = 8'h22; d = 8'h33; s1 = 1'b0; s2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(exp);
            checks++;
            if (res !== 8'h00 || exp !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h want 00", i, res);
            end
        end
        rst = 1'b0;
        step(exp);
        checks++;
        if (res !== 8'hFF) begin
            errors++;
            $display("FAIL reset_release got %h want ff", res);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        logic [7:0] want [4];
        want[0] = 8'h00; want[1] = 8'hF0; want[2] = 8'h0F; want[3] = 8'hFF;
        a = 8'h00; b = 8'hF0; c = 8'h0F; d = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            s1 = i[0]; s2 = i[1];
            step(exp);
            checks++;
            if (res !== want[i] || res !== exp) begin
                errors++;
                $display("FAIL sweep_sel%0d got %h want %h", i, res, want[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp;
        s1 = 1'b1; s2 = 1'b0; b = 8'h5A;
        step(exp);
        checks++;
        if (res !== 8'h5A) begin
            errors++;
            $display("FAIL latency_load got %h want 5a", res);
        end
        b = 8'hA5;
        #2;
        checks++;
        if (res !== 8'h5A) begin
            errors++;
            $display("FAIL latency_between_edges got %h want 5a", res);
        end
        a = 8'h13; c = 8'h57; d = 8'h9B;
        #1;
        checks++;
        if (res !== 8'h5A) begin
            errors++;
            $display("FAIL latency_unselected got %h want 5a", res);
        end
        step(exp);
        checks++;
        if (res !== 8'hA5) begin
            errors++;
            $display("FAIL latency_next_edge got %h want a5", res);
        end
        // Switching select with constant data also waits for the edge.
        s1 = 1'b0; s2 = 1'b1;
        #2;
        checks++;
        if (res !== 8'hA5) begin
            errors++;
            $display("FAIL sel_change_between_edges got %h want a5", res);
        end
        step(exp);
        checks++;
        if (res !== 8'h57) begin
            errors++;
            $display("FAIL sel_change_edge got %h want 57", res);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] exp;
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        for (int i = 0; i < 6; i++) begin
            s1 = i[0]; s2 = i[1];
            rst = (i == 3);
            step(exp);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL midreset[%0d] got %h want %h", i, res, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_walking();
        logic [7:0] exp;
        logic [7:0] w;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                w = 8'h01 << k;
                a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
                case (s)
                    0: a = w;
                    1: b = w;
                    2: c = w;
                    default: d = w;
                endcase
                // Fill the unselected sources with the complement to expose leakage.
                if (s != 0) a = ~w;
                if (s != 1) b = ~w;
                if (s != 2) c = ~w;
                if (s != 3) d = ~w;
                s1 = s[0]; s2 = s[1];
                step(exp);
                checks++;
                if (res !== w) begin
                    errors++;
                    $display("FAIL walk_sel%0d_bit%0d got %h want %h", s, k, res, w);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            s1 = 1'($urandom); s2 = 1'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            step(exp);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL random[%0d] got %h want %h", i, res, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; c = '0; d = '0; s1 = 1'b0; s2 = 1'b0;
        #1;
        test_reset();
        test_sweep();
        test_latency();
        test_midreset();
        test_walking();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
